hamming_decoder: RTL and testbench

Pipelined Hamming(7,4) single-error corrector that sits directly downstream of the error-injection stage. It accepts 7-bit codewords, computes the 3-bit syndrome, flips the indicated bit and delivers the 4-bit data word, the correction flag and the corrected bit index. It uses valid/ready handshakes on both sides and keeps saturating statistics counters.

---
 rtl/hamming_decoder_pkg.sv | 32 +++
 rtl/hamming_decoder_if.sv | 27 ++
 rtl/hamming_syndrome.sv | 13 +
 rtl/hamming_decoder.sv | 142 ++++++++++++++
 tb/tb_hamming_decoder.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/hamming_decoder_pkg.sv
// hamming_pkg: shared constants and helpers for the Hamming(7,4) blocks.
// Bit i of a codeword holds Hamming position i+1. Parity bits sit at
// positions 0, 1, 3 and data bits at 2, 4, 5, 6.
package hamming_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  localparam int P0_POS = 0;
  localparam int P1_POS = 1;
  localparam int P2_POS = 3;

  localparam int D0_POS = 2;
  localparam int D1_POS = 4;
  localparam int D2_POS = 5;
  localparam int D3_POS = 6;

  // A nonzero syndrome is the 1-based index of the erroneous bit.
  function automatic logic [SYN_W-1:0] syndrome(input logic [CODE_W-1:0] c);
    logic [SYN_W-1:0] s;
    s[0] = c[P0_POS] ^ c[D0_POS] ^ c[D1_POS] ^ c[D3_POS];
    s[1] = c[P1_POS] ^ c[D0_POS] ^ c[D2_POS] ^ c[D3_POS];
    s[2] = c[P2_POS] ^ c[D1_POS] ^ c[D2_POS] ^ c[D3_POS];
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] c);
    return {c[D3_POS], c[D2_POS], c[D1_POS], c[D0_POS]};
  endfunction

endpackage

// File: rtl/hamming_decoder_if.sv
// hamming_decoder_if: valid/ready input (codeword) and output (result) channels
// of the Hamming decoder.
//   slave  : decoder side
//   master : producer/consumer side
interface hamming_decoder_if;
  import hamming_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [CODE_W-1:0]       in_code;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic                    out_err;
  logic [SYN_W-1:0]        out_pos;

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data, out_err, out_pos
  );

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data, out_err, out_pos
  );

endinterface

// File: rtl/hamming_syndrome.sv
// hamming_syndrome: combinational Hamming(7,4) syndrome.
//   code_i : received 7-bit codeword
//   syn_o  : 3-bit syndrome, 0 = clean, else 1-based error position
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [SYN_W-1:0]  syn_o
);

  assign syn_o = syndrome(code_i);

endmodule

// File: rtl/hamming_decoder.sv
// hamming_decoder: two-stage pipelined Hamming(7,4) single-error corrector
// with saturating clean/corrected statistics counters.
//   clk, rst_n          : clock, async active-low reset
//   bus (slave)         : in_valid/in_ready/in_code, out_valid/out_ready/
//                         out_data/out_err/out_pos
//   clr_cnt             : synchronous clear of both counters (wins over increment)
//   cnt_clean, cnt_corr : delivered words with zero / nonzero syndrome
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  hamming_decoder_if.slave  bus,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_clean,
  output logic [CNT_W-1:0]  cnt_corr
);

  logic                s1_valid_q, s1_valid_d;
  logic [CODE_W-1:0]   s1_code_q,  s1_code_d;
  logic [SYN_W-1:0]    s1_syn_q,   s1_syn_d;
  logic                s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0]   s2_data_q,  s2_data_d;
  logic                s2_err_q,   s2_err_d;
  logic [SYN_W-1:0]    s2_pos_q,   s2_pos_d;
  logic [CNT_W-1:0]    cnt_clean_q, cnt_clean_d;
  logic [CNT_W-1:0]    cnt_corr_q,  cnt_corr_d;

  logic [SYN_W-1:0]    in_syn;
  logic                s2_ready;
  logic                in_hs;
  logic                s1_fwd;
  logic                out_hs;
  logic [CODE_W-1:0]   corr_code;
  logic                corr_err;
  logic [SYN_W-1:0]    corr_pos;

  hamming_syndrome u_syn (
    .code_i (bus.in_code),
    .syn_o  (in_syn)
  );

  // S2 frees up when empty or when its word leaves this cycle; S1 can then
  // advance, so in_ready is combinational from out_ready.
  assign s2_ready     = !s2_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid_q || !s2_valid_q || bus.out_ready;
  assign in_hs        = bus.in_valid && bus.in_ready;
  assign s1_fwd       = s1_valid_q && s2_ready;
  assign out_hs       = s2_valid_q && bus.out_ready;

  always_comb begin
    corr_code = s1_code_q;
    corr_err  = (s1_syn_q != '0);
    corr_pos  = '0;
    if (corr_err) begin
      corr_pos = s1_syn_q - SYN_W'(1);
    end
    for (int i = 0; i < CODE_W; i++) begin
      if (s1_syn_q == SYN_W'(i + 1)) begin
        corr_code[i] = ~s1_code_q[i];
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_syn_d   = s1_syn_q;
    if (in_hs) begin
      s1_valid_d = 1'b1;
      s1_code_d  = bus.in_code;
      s1_syn_d   = in_syn;
    end else if (s1_fwd) begin
      s1_valid_d = 1'b0;
    end
  end

  // Output fields only change on a load, so they hold while stalled.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_err_d   = s2_err_q;
    s2_pos_d   = s2_pos_q;
    if (s1_fwd) begin
      s2_valid_d = 1'b1;
      s2_data_d  = extract_data(corr_code);
      s2_err_d   = corr_err;
      s2_pos_d   = corr_pos;
    end else if (out_hs) begin
      s2_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_clean_d = cnt_clean_q;
    cnt_corr_d  = cnt_corr_q;
    if (clr_cnt) begin
      cnt_clean_d = '0;
      cnt_corr_d  = '0;
    end else if (out_hs) begin
      if (s2_err_q) begin
        if (cnt_corr_q != '1) cnt_corr_d = cnt_corr_q + CNT_W'(1);
      end else begin
        if (cnt_clean_q != '1) cnt_clean_d = cnt_clean_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_code_q   <= '0;
      s1_syn_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_err_q    <= 1'b0;
      s2_pos_q    <= '0;
      cnt_clean_q <= '0;
      cnt_corr_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_code_q   <= s1_code_d;
      s1_syn_q    <= s1_syn_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_err_q    <= s2_err_d;
      s2_pos_q    <= s2_pos_d;
      cnt_clean_q <= cnt_clean_d;
      cnt_corr_q  <= cnt_corr_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_err   = s2_err_q;
  assign bus.out_pos   = s2_pos_q;
  assign cnt_clean     = cnt_clean_q;
  assign cnt_corr      = cnt_corr_q;

endmodule

// File: tb/tb_hamming_decoder.sv
module tb_hamming_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr1 = 1'b0;
  logic        clr2 = 1'b0;
  logic [15:0] cc1, cr1;
  logic [1:0]  cc2, cr2;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  hamming_decoder_if if1 ();
  hamming_decoder_if if2 ();

  hamming_decoder dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1),
    .clr_cnt(clr1), .cnt_clean(cc1), .cnt_corr(cr1)
  );

  hamming_decoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2),
    .clr_cnt(clr2), .cnt_clean(cc2), .cnt_corr(cr2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] c;
    c = '0;
    c[2] = d[0];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    c[0] = c[2] ^ c[4] ^ c[6];
    c[1] = c[2] ^ c[5] ^ c[6];
    c[3] = c[4] ^ c[5] ^ c[6];
    return c;
  endfunction

  // Waits (bounded) for a result on if1 at a falling edge, then checks it.
  task automatic expect1(input string tag, input logic [3:0] d, input logic e, input logic [2:0] p);
    for (int i = 0; i < 10; i++) begin
      if (if1.out_valid === 1'b1) break;
      @(negedge clk);
    end
    chk({tag, "_valid"}, 32'(if1.out_valid), 32'd1);
    chk({tag, "_data"},  32'(if1.out_data),  32'(d));
    chk({tag, "_err"},   32'(if1.out_err),   32'(e));
    chk({tag, "_pos"},   32'(if1.out_pos),   32'(p));
  endtask

  logic [6:0] codes [3];
  logic [2:0] poss  [3];
  logic [6:0] c;
  logic [3:0] ed;
  int         sent, got, start_cyc, k;

  initial begin
    if1.in_valid = 1'b0; if1.in_code = '0; if1.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.in_code = '0; if2.out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(if1.out_valid), 32'd0);
    chk("rst_out_data",  32'(if1.out_data),  32'd0);
    chk("rst_out_err",   32'(if1.out_err),   32'd0);
    chk("rst_out_pos",   32'(if1.out_pos),   32'd0);
    chk("rst_cnt_clean", 32'(cc1), 32'd0);
    chk("rst_cnt_corr",  32'(cr1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(if1.in_ready), 32'd1);

    // clean word, two-edge latency
    if1.in_valid = 1'b1; if1.in_code = 7'b1010101;
    @(negedge clk);
    if1.in_valid = 1'b0;
    chk("clean_lat1_valid", 32'(if1.out_valid), 32'd0);
    @(negedge clk);
    expect1("clean", 4'b1011, 1'b0, 3'd0);
    @(negedge clk);
    chk("clean_cnt_clean", 32'(cc1), 32'd1);
    chk("clean_gone",      32'(if1.out_valid), 32'd0);

    // single-bit errors at positions 0, 3, 6
    codes[0] = 7'b1010100; poss[0] = 3'd0;
    codes[1] = 7'b1011101; poss[1] = 3'd3;
    codes[2] = 7'b0010101; poss[2] = 3'd6;
    for (int i = 0; i < 3; i++) begin
      if1.in_valid = 1'b1; if1.in_code = codes[i];
      @(negedge clk);
      if1.in_valid = 1'b0;
      expect1("single", 4'b1011, 1'b1, poss[i]);
      @(negedge clk);
    end
    chk("single_cnt_corr",  32'(cr1), 32'd3);
    chk("single_cnt_clean", 32'(cc1), 32'd1);

    // exhaustive back-to-back stream
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    chk("clr_cnt_clean", 32'(cc1), 32'd0);
    chk("clr_cnt_corr",  32'(cr1), 32'd0);
    sent = 0; got = 0; start_cyc = cyc;
    while (got < 128 && (cyc - start_cyc) < 200) begin
      if (if1.out_valid === 1'b1) begin
        k  = got % 8;
        ed = 4'(got / 8);
        chk("exh_data", 32'(if1.out_data), 32'(ed));
        chk("exh_err",  32'(if1.out_err),  (k != 0) ? 32'd1 : 32'd0);
        chk("exh_pos",  32'(if1.out_pos),  (k != 0) ? 32'(k - 1) : 32'd0);
        got++;
      end
      if (sent < 128) begin
        c = enc(4'(sent / 8));
        k = sent % 8;
        if (k != 0) c[k-1] = ~c[k-1];
        if1.in_valid = 1'b1; if1.in_code = c;
        sent++;
      end else begin
        if1.in_valid = 1'b0;
      end
      if (got < 128) @(negedge clk);
    end
    if1.in_valid = 1'b0;
    chk("exh_count",  32'(got), 32'd128);
    chk("exh_cycles", 32'(cyc - start_cyc), 32'd129);
    @(negedge clk);
    chk("exh_cnt_clean", 32'(cc1), 32'd16);
    chk("exh_cnt_corr",  32'(cr1), 32'd112);

    // backpressure: A clean(3), B = data 9 with bit 5 flipped, C clean(14)
    if1.out_ready = 1'b0;
    if1.in_valid  = 1'b1; if1.in_code = enc(4'd3);
    chk("bp_ready0", 32'(if1.in_ready), 32'd1);
    @(negedge clk);
    chk("bp_ready1", 32'(if1.in_ready), 32'd1);
    c = enc(4'd9); c[5] = ~c[5];
    if1.in_code = c;
    @(negedge clk);
    chk("bp_full_ready", 32'(if1.in_ready),  32'd0);
    chk("bp_full_valid", 32'(if1.out_valid), 32'd1);
    chk("bp_full_data",  32'(if1.out_data),  32'd3);
    if1.in_code = enc(4'd14);
    @(negedge clk);
    chk("bp_hold_ready", 32'(if1.in_ready), 32'd0);
    chk("bp_hold_data",  32'(if1.out_data), 32'd3);
    chk("bp_hold_err",   32'(if1.out_err),  32'd0);
    chk("bp_hold_pos",   32'(if1.out_pos),  32'd0);
    if1.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(if1.in_ready), 32'd1);
    @(negedge clk);
    if1.in_valid = 1'b0;
    expect1("bp_B", 4'd9, 1'b1, 3'd5);
    @(negedge clk);
    expect1("bp_C", 4'd14, 1'b0, 3'd0);
    @(negedge clk);
    chk("bp_no_dup", 32'(if1.out_valid), 32'd0);
    chk("bp_cnt_clean", 32'(cc1), 32'd18);
    chk("bp_cnt_corr",  32'(cr1), 32'd113);

    // saturation on the 2-bit counter instance
    for (int i = 0; i < 5; i++) begin
      if2.in_valid = 1'b1; if2.in_code = enc(4'(i));
      @(negedge clk);
    end
    if2.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat_cnt_clean", 32'(cc2), 32'd3);
    chk("sat_cnt_corr",  32'(cr2), 32'd0);
    if2.in_valid = 1'b1; if2.in_code = enc(4'd7);
    @(negedge clk);
    if2.in_valid = 1'b0;
    @(negedge clk);
    chk("clr_deliver_valid", 32'(if2.out_valid), 32'd1);
    clr2 = 1'b1;
    @(negedge clk);
    clr2 = 1'b0;
    chk("clr_prio_cnt", 32'(cc2), 32'd0);
    chk("clr_delivered", 32'(if2.out_valid), 32'd0);

    // reset with both stages full
    if1.out_ready = 1'b0;
    if1.in_valid = 1'b1; if1.in_code = enc(4'd5);
    @(negedge clk);
    if1.in_code = enc(4'd6);
    @(negedge clk);
    if1.in_valid = 1'b0;
    chk("mrst_full_ready", 32'(if1.in_ready),  32'd0);
    chk("mrst_full_valid", 32'(if1.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid_now", 32'(if1.out_valid), 32'd0);
    chk("mrst_cnt_clean", 32'(cc1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    if1.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mrst_no_stale", 32'(if1.out_valid), 32'd0);
    end
    chk("mrst_in_ready", 32'(if1.in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
